// File: rtl/thee_lpf_pkg.sv
// Shared types and helpers for the time-multiplexed moving-average filter.
package thee_lpf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    OUT   = 2'd3
  } lpf_state_t;

  // Accumulator width: summing TAPS samples of DW bits needs log2(TAPS) headroom bits.
  function automatic int acc_width(input int dw, input int taps);
    return dw + $clog2(taps);
  endfunction

  // True for powers of two that are at least 2.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/thee_rr_arbiter.sv
// Combinational round-robin search: first requester after the last grant, wrapping.
module thee_rr_arbiter #(
  parameter int NCH = 4,
  localparam int IW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  last_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o,
  output logic           any_o
);

  logic [IW-1:0] cand;
  logic          found;

  // Walk the channels starting one past the last grant; the first active request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NCH; off++) begin
      cand = IW'((int'(last_i) + off) % NCH);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/thee_lpf_channel_scheduler.sv
// Shares one moving-average accumulator between NCH channels, each with its own
// TAPS-deep circular history; results leave over a valid/ready port tagged by channel.
module thee_lpf_channel_scheduler
  import thee_lpf_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int TAPS = 4,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*DW-1:0]       req_data,
  output logic [NCH-1:0]          req_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NCH)-1:0]  out_chan,
  output logic signed [DW-1:0]    out_data,
  output logic                    busy
);

  localparam int IW = $clog2(NCH);
  localparam int TW = $clog2(TAPS);
  localparam int AW = acc_width(DW, TAPS);

  if (!is_pow2(TAPS)) begin : g_chk_taps
    $error("TAPS must be a power of two and at least 2");
  end
  if (NCH < 2) begin : g_chk_nch
    $error("NCH must be at least 2");
  end

  lpf_state_t state_q, state_d;

  logic [IW-1:0]        last_q;
  logic [IW-1:0]        g_q;
  logic signed [DW-1:0] sample_q;
  logic [TW-1:0]        wp_q   [NCH];
  logic signed [DW-1:0] hist_q [NCH][TAPS];
  logic signed [AW-1:0] acc_q;
  logic [TW-1:0]        k_q;
  logic signed [DW-1:0] out_data_q;
  logic [IW-1:0]        out_chan_q;
  logic                 out_valid_q;
  logic                 flush_pending_q;

  logic [NCH-1:0]       gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 flush_now;
  logic                 handshake;
  logic                 last_tap;
  logic signed [DW-1:0] tap_val;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] acc_shift;

  thee_rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  assign flush_now = flush || flush_pending_q;
  assign handshake = (state_q == IDLE) && !flush_now && gnt_any && !rst;
  assign last_tap  = (k_q == TW'(TAPS - 1));
  assign tap_val   = hist_q[g_q][k_q];
  assign acc_sum   = acc_q + $signed({{TW{tap_val[DW-1]}}, tap_val});
  assign acc_shift = acc_sum >>> TW;

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;

  // Next-state and grant decode; grants only in IDLE when no flush is due.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (!flush_now && !rst) begin
          req_ready = gnt;
          if (gnt_any) state_d = LOAD;
        end
      end
      LOAD:    state_d = ACCUM;
      ACCUM:   if (last_tap) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, history storage, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_q          <= IW'(NCH - 1);
      g_q             <= '0;
      sample_q        <= '0;
      acc_q           <= '0;
      k_q             <= '0;
      out_data_q      <= '0;
      out_chan_q      <= '0;
      out_valid_q     <= 1'b0;
      flush_pending_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        wp_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) hist_q[c][t] <= '0;
      end
    end else begin
      state_q <= state_d;
      // A flush arriving mid-transaction waits until the result has been delivered.
      if (state_q != IDLE && flush) flush_pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (flush_now) begin
            flush_pending_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
              wp_q[c] <= '0;
              for (int t = 0; t < TAPS; t++) hist_q[c][t] <= '0;
            end
          end else if (handshake) begin
            sample_q <= req_data[gnt_idx*DW +: DW];
            g_q      <= gnt_idx;
            last_q   <= gnt_idx;
          end
        end
        LOAD: begin
          hist_q[g_q][wp_q[g_q]] <= sample_q;
          wp_q[g_q]              <= wp_q[g_q] + TW'(1);
          acc_q                  <= '0;
          k_q                    <= '0;
        end
        ACCUM: begin
          acc_q <= acc_sum;
          k_q   <= k_q + TW'(1);
          if (last_tap) begin
            out_data_q  <= acc_shift[DW-1:0];
            out_chan_q  <= g_q;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
